// File: rtl/xm_latch_elastic.sv
// ---------------------------------------------------------------------------
// xm_latch_elastic
// Elastic execute->memory pipeline latch. Carries ALU result, store data,
// destination register and a control vector (bit0 wMem, bit1 wReg, bit2 lw)
// over a valid/ready handshake.
//   SKID=1 : head register M plus skid register S; inReady is registered
//            (~sV), so there is no path from outReady to inReady.
//   SKID=0 : single head register; inReady = ~mV | outReady.
// flush kills every held entry at the next edge; a same-cycle input is
// dropped, and a same-cycle pop still counts as delivered.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   inValid/inReady       upstream handshake
//   oIn, dIn, rdIn, ctrlIn  incoming payload
//   flush                 synchronous kill of all entries
//   outValid/outReady     downstream handshake
//   oOut, dOut            head payload (hold last value when empty)
//   rdOut, ctrlOut        head payload, forced to 0 when outValid=0
//   count                 number of held entries
//
// State table (state = {mV,sV})
//   state | meaning
//   EMPTY | nothing held, inReady=1
//   ONE   | head M valid, inReady=1
//   FULL  | M and skid S valid, inReady=0 (SKID=1 only)
// ---------------------------------------------------------------------------
module xm_latch_elastic #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 3,
   parameter int SKID   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inValid,
   output logic              inReady,
   input  logic [DATA_W-1:0] oIn,
   input  logic [DATA_W-1:0] dIn,
   input  logic [RD_W-1:0]   rdIn,
   input  logic [CTRL_W-1:0] ctrlIn,
   input  logic              flush,
   output logic              outValid,
   input  logic              outReady,
   output logic [DATA_W-1:0] oOut,
   output logic [DATA_W-1:0] dOut,
   output logic [RD_W-1:0]   rdOut,
   output logic [CTRL_W-1:0] ctrlOut,
   output logic [1:0]        count
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } stateT;

   stateT             stateQ, stateNxt;
   logic              mV, sV;
   logic              accept, pop;
   logic              loadMIn, loadMS, loadS;

   logic [DATA_W-1:0] mO, mD, sO, sD;
   logic [RD_W-1:0]   mRd, sRd;
   logic [CTRL_W-1:0] mCtrl, sCtrl;

   assign mV = stateQ[1];
   assign sV = stateQ[0];

   assign inReady  = (SKID != 0) ? ~sV : (~mV | outReady);
   assign outValid = mV;
   assign accept   = inValid & inReady;
   assign pop      = mV & outReady;

   always_comb begin
      stateNxt = stateQ;
      loadMIn  = 1'b0;
      loadMS   = 1'b0;
      loadS    = 1'b0;
      case (stateQ)
         EMPTY: begin
            if (accept) begin
               loadMIn  = 1'b1;
               stateNxt = ONE;
            end
         end
         ONE: begin
            if (accept && (pop || SKID == 0)) begin
               // head leaves (or single-entry overwrite on pop): refill M
               loadMIn  = 1'b1;
            end else if (accept) begin
               loadS    = 1'b1;
               stateNxt = FULL;
            end else if (pop) begin
               stateNxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               loadMS   = 1'b1;
               stateNxt = ONE;
            end
         end
         default: stateNxt = EMPTY;
      endcase
      if (flush) begin
         stateNxt = EMPTY;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateQ <= EMPTY;
         mO     <= '0;
         mD     <= '0;
         mRd    <= '0;
         mCtrl  <= '0;
         sO     <= '0;
         sD     <= '0;
         sRd    <= '0;
         sCtrl  <= '0;
      end else begin
         stateQ <= stateNxt;
         if (flush) begin
            // data fields may keep stale values; rd/ctrl must not
            mRd   <= '0;
            mCtrl <= '0;
            sRd   <= '0;
            sCtrl <= '0;
         end else begin
            if (loadMIn) begin
               mO    <= oIn;
               mD    <= dIn;
               mRd   <= rdIn;
               mCtrl <= ctrlIn;
            end else if (loadMS) begin
               mO    <= sO;
               mD    <= sD;
               mRd   <= sRd;
               mCtrl <= sCtrl;
            end
            if (loadS) begin
               sO    <= oIn;
               sD    <= dIn;
               sRd   <= rdIn;
               sCtrl <= ctrlIn;
            end
         end
      end
   end

   assign oOut    = mO;
   assign dOut    = mD;
   // hazard logic must never see a stale wReg/rd from an empty latch
   assign rdOut   = mV ? mRd   : '0;
   assign ctrlOut = mV ? mCtrl : '0;
   assign count   = {1'b0, mV} + {1'b0, sV};

endmodule

// File: doc/xm_latch_elastic.md
Name: xm_latch_elastic

Overview:
- Parametrised, elastic successor to the fixed X/M pipeline latch.
- Carries the ALU result, store data, destination register and an arbitrary control-bit vector from execute to memory.
- Uses a valid/ready handshake with a 2-entry skid buffer, plus synchronous flush.
- Upstream stages can stall on downstream backpressure without a combinational ready path (SKID=1). SKID=0 gives a minimal 1-entry mode.

Parameters:
- DATA_W, 32, width of oIn/dIn/oOut/dOut.
- RD_W, 5, destination register index width.
- CTRL_W, 3, control vector width; bit0 = wMem, bit1 = wReg, bit2 = lw.
- SKID, 1, 1 = 2-entry skid buffer with registered inReady; 0 = single entry with combinational inReady.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- inValid  in  1  upstream has an instruction.
- inReady  out  1  latch can accept this cycle.
- oIn  in  DATA_W  ALU result.
- dIn  in  DATA_W  store data.
- rdIn  in  RD_W  destination register.
- ctrlIn  in  CTRL_W  control bits.
- flush  in  1  synchronous kill of all held entries.
- outValid  out  1  head entry valid.
- outReady  in  1  downstream accepts the head.
- oOut  out  DATA_W  head ALU result.
- dOut  out  DATA_W  head store data.
- rdOut  out  RD_W  head destination; 0 when outValid=0.
- ctrlOut  out  CTRL_W  head control; 0 when outValid=0.
- count  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (reset=0, async) clears all storage to 0, so outValid=0, count=0, ctrlOut=0 and rdOut=0. With SKID=1, inReady=1 while in reset and immediately after.
- Handshake:
  - accept = inValid & inReady; pop = outValid & outReady, both sampled at the rising edge.
  - Data appears on the outputs 1 cycle after accept when the latch was empty (latency 1).
  - Head payload is stable while outValid=1 & outReady=0.
- Storage: head register M (valid mV) and skid register S (valid sV, used only when SKID=1).
- State machine for SKID=1; the state is {mV,sV}:
  - EMPTY (0,0): inReady=1. accept -> M<=in, go ONE.
  - ONE (1,0): inReady=1.
    - accept & pop -> M<=in, stay ONE.
    - accept only -> S<=in, go FULL.
    - pop only -> go EMPTY.
  - FULL (1,1): inReady=0. pop -> M<=S, go ONE. Otherwise hold.
  - inReady is a pure function of registered state (inReady = ~sV). There is no path from outReady to inReady.
- SKID=0 mode:
  - inReady = ~mV | outReady (combinational).
  - accept -> M<=in, mV=1. pop without accept -> mV=0.
- Flush:
  - Highest priority. At the edge with flush=1: mV, sV <= 0, and M/S control and rd fields <= 0.
  - Any input accepted in the same cycle is discarded. A head popped in the same cycle counts as delivered.
  - Next cycle: count=0, outValid=0, inReady=1.
- Output gating: ctrlOut and rdOut are forced to 0 whenever outValid=0, so hazard/forwarding logic never sees stale wReg/rd. oOut and dOut hold their last value.
- count = mV + sV. Ordering is strictly FIFO; an entry is never duplicated or dropped except by flush.
- Reset asserted mid-transfer: immediate clear. No partial entry survives; the first edge after deassertion behaves as EMPTY.

Test Plan:
1. Reset, then inValid=1, oIn=0x0000_00A5, rdIn=7, ctrlIn=3'b010, outReady=1 for 1 cycle -> next cycle outValid=1, oOut=0xA5, rdOut=7, ctrlOut=010, count=1. Following cycle outValid=0, rdOut=0, ctrlOut=0.
2. SKID=1, outReady=0, push A (oIn=1), B (oIn=2), C (oIn=3) on consecutive cycles -> count=1 then 2; inReady=0 after B; C not accepted. Raise outReady -> outputs A then B, then C once re-offered. oOut sequence 1, 2, 3.
3. Streaming: inValid=1 and outReady=1 for 8 cycles with oIn=0..7 -> outValid stays 1 from cycle 1, oOut=0..7 in order, count stays 1, inReady stays 1.
4. FULL state (count=2), assert flush with inValid=1 (oIn=0xFF) -> next cycle count=0, outValid=0, ctrlOut=0, inReady=1; 0xFF never appears on oOut.
5. Assert reset=0 asynchronously mid-cycle while count=2 -> outValid, count and ctrlOut drop to 0 without waiting for a clock edge. After release, a push of 0x10 appears 1 cycle later.
6. SKID=0, head valid, outReady=1, inValid=1 -> inReady=1 in the same cycle. With outReady=0 and head valid -> inReady=0. Single-entry throughput of 1 per cycle is verified.
